canal_ctrl: RTL and testbench

Configuration and sequencing controller for one audio channel (lowpass → downsample → requantize → interpolate, each with a bypass mux). It generates the 48 kHz sample strobe `data_en` and synchronizes and debounces the user switch settings. It drives the four mux selects and the `Nfreq`, `Nquant` and `K` factors. Configuration changes are applied only on a decimation-frame boundary, and the channel output is muted around each change so no corrupted samples reach the DAC.

---
 rtl/canal_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_canal_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/canal_ctrl.sv
// canal_ctrl - configuration and sequencing controller for one audio channel
// (lowpass -> downsample -> requantize -> interpolate, each with a bypass mux).
//
// Generates the sample strobe, synchronizes and debounces the user switch
// settings, and applies a new configuration only on a decimation-frame
// boundary. The channel is muted before the change and for MUTE_SAMPLES
// strobes after it.
//
// Parameters:
//   CLK_DIV        master clocks per sample period (>= 2)
//   STABLE_SAMPLES strobes a new request must hold before it is accepted
//   MUTE_SAMPLES   strobes the mute stays asserted after a change is applied
//
// Ports:
//   clock        master clock
//   reset        asynchronous, active-low reset
//   switches     [0] filter en, [1] downsample en, [2] requant en,
//                [3] interp en, [7:4] requested Nfreq
//   nquant_req   requested quantization bits
//   data_en      one-cycle sample strobe, period CLK_DIV
//   frame_start  data_en qualified with decimation phase 0
//   sel_*        mux selects (1 = processed path, 0 = bypass)
//   Nfreq/Nquant/K  active downsample, quantization and interpolation factors
//   mute         forces the channel output to zero
//   busy         high whenever the controller is not idle in RUN
//
// Optional build macro CANAL_CTRL_STATUS_EN adds:
//   cfg_count    saturating count of applied configurations
//   clamp_flag   sticky flag: an applied configuration had a clamped factor
module canal_ctrl #(
    parameter int CLK_DIV        = 2083,
    parameter int STABLE_SAMPLES = 4,
    parameter int MUTE_SAMPLES   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] switches,
    input  logic [4:0] nquant_req,
    output logic       data_en,
    output logic       frame_start,
    output logic       sel_filter,
    output logic       sel_down,
    output logic       sel_requant,
    output logic       sel_interp,
    output logic [3:0] Nfreq,
    output logic [4:0] Nquant,
    output logic [3:0] K,
    output logic       mute,
    output logic       busy
`ifdef CANAL_CTRL_STATUS_EN
    ,
    output logic [7:0] cfg_count,
    output logic       clamp_flag
`endif
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);
    localparam int MUTE_W = $clog2(MUTE_SAMPLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [MUTE_W-1:0] MUTE_LAST = MUTE_W'(MUTE_SAMPLES - 1);

    typedef struct packed {
        logic [3:0] sels;    // {filter, down, requant, interp}
        logic [3:0] nfreq;
        logic [4:0] nquant;
        logic [3:0] k;
    } cfg_t;

    localparam cfg_t RESET_CFG = '{sels: 4'h0, nfreq: 4'd1, nquant: 5'd18, k: 4'd1};

    typedef enum logic [2:0] {
        RUN,
        DEBOUNCE,
        WAIT_BOUNDARY,
        APPLY,
        MUTE
    } state_t;

    state_t            state;
    cfg_t              act;
    cfg_t              cand;
    cfg_t              req;
    logic [7:0]        sw_s1, sw_s2;
    logic [4:0]        nq_s1, nq_s2;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [3:0]        phase, phase_nxt;
    logic [STAB_W-1:0] stab_cnt;
    logic [MUTE_W-1:0] mute_cnt;
    logic              nf_zero, nq_low, nq_high;
    logic              cand_load;

    // Synchronizers reset to values that normalize to the reset configuration,
    // so leaving reset does not look like a change request by itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            nq_s1 <= 5'd18;
            nq_s2 <= 5'd18;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
            nq_s1 <= nquant_req;
            nq_s2 <= nq_s1;
        end
    end

    // Request normalization
    always_comb begin
        nf_zero    = (sw_s2[7:4] == 4'd0);
        nq_low     = (nq_s2 == 5'd0);
        nq_high    = (nq_s2 > 5'd18);
        req        = RESET_CFG;
        req.sels   = {sw_s2[0], sw_s2[1], sw_s2[2], sw_s2[3]};
        req.nfreq  = !sw_s2[1] ? 4'd1 : (nf_zero ? 4'd1 : sw_s2[7:4]);
        req.nquant = nq_low ? 5'd1 : (nq_high ? 5'd18 : nq_s2);
        req.k      = sw_s2[3] ? req.nfreq : 4'd1;
    end

    // Candidate is (re)loaded when a new request appears in RUN, or when the
    // request moves to a third value during debounce.
    always_comb begin
        cand_load = 1'b0;
        if (state == RUN)
            cand_load = (req != act);
        else if (state == DEBOUNCE)
            cand_load = data_en && (req != cand) && (req != act);
    end

    // Strobe and decimation phase; outputs are computed one cycle ahead so
    // that data_en and frame_start come straight from flops.
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        if (state == APPLY)
            phase_nxt = '0;
        else if (data_en)
            phase_nxt = (phase >= act.nfreq - 4'd1) ? '0 : phase + 4'd1;
        else
            phase_nxt = phase;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            data_en     <= 1'b0;
            phase       <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            data_en     <= (div_nxt == DIV_LAST);
            phase       <= phase_nxt;
            frame_start <= (div_nxt == DIV_LAST) && (phase_nxt == 4'd0);
        end
    end

    // Sequencing FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            act      <= RESET_CFG;
            cand     <= RESET_CFG;
            stab_cnt <= '0;
            mute_cnt <= '0;
            mute     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (cand_load) begin
                cand     <= req;
                stab_cnt <= '0;
            end
            case (state)
                RUN: begin
                    if (cand_load) begin
                        state <= DEBOUNCE;
                        busy  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (data_en) begin
                        if (req == cand) begin
                            stab_cnt <= stab_cnt + 1'b1;
                            if (stab_cnt == STAB_LAST) begin
                                state <= WAIT_BOUNDARY;
                                mute  <= 1'b1;
                            end
                        end else if (req == act) begin
                            state <= RUN;
                            busy  <= 1'b0;
                        end
                    end
                end
                WAIT_BOUNDARY: begin
                    if (frame_start)
                        state <= APPLY;
                end
                APPLY: begin
                    act      <= cand;
                    mute_cnt <= '0;
                    state    <= MUTE;
                end
                MUTE: begin
                    if (data_en) begin
                        mute_cnt <= mute_cnt + 1'b1;
                        if (mute_cnt == MUTE_LAST) begin
                            state <= RUN;
                            mute  <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    mute  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {sel_filter, sel_down, sel_requant, sel_interp} = act.sels;
    assign Nfreq  = act.nfreq;
    assign Nquant = act.nquant;
    assign K      = act.k;

`ifdef CANAL_CTRL_STATUS_EN
    logic cand_clamp;

    // Clamp status rides along with the candidate so the flag reflects what
    // was actually applied, not what the switches show at APPLY time.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand_clamp <= 1'b0;
            cfg_count  <= '0;
            clamp_flag <= 1'b0;
        end else begin
            if (cand_load)
                cand_clamp <= (sw_s2[1] && nf_zero) || nq_low || nq_high;
            if (state == APPLY) begin
                if (cfg_count != 8'hFF)
                    cfg_count <= cfg_count + 8'd1;
                if (cand_clamp)
                    clamp_flag <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_canal_ctrl.sv
// Directed bench for canal_ctrl with CLK_DIV=10, STABLE_SAMPLES=4,
// MUTE_SAMPLES=16. Inputs change and outputs are sampled on the falling edge;
// "cycle N" below counts rising edges since the reference point.
module tb_canal_ctrl;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic [7:0] switches   = 8'h00;
    logic [4:0] nquant_req = 5'd18;
    logic       data_en, frame_start;
    logic       sel_filter, sel_down, sel_requant, sel_interp;
    logic [3:0] Nfreq, K;
    logic [4:0] Nquant;
    logic       mute, busy;
`ifdef CANAL_CTRL_STATUS_EN
    logic [7:0] cfg_count;
    logic       clamp_flag;
`endif

    int n_cmp       = 0;
    int n_bad       = 0;
    int mute_cycles = 0;
    int took;

    always #5 clock = ~clock;

    always @(negedge clock)
        if (mute === 1'b1)
            mute_cycles = mute_cycles + 1;

    canal_ctrl #(
        .CLK_DIV       (10),
        .STABLE_SAMPLES(4),
        .MUTE_SAMPLES  (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .switches   (switches),
        .nquant_req (nquant_req),
        .data_en    (data_en),
        .frame_start(frame_start),
        .sel_filter (sel_filter),
        .sel_down   (sel_down),
        .sel_requant(sel_requant),
        .sel_interp (sel_interp),
        .Nfreq      (Nfreq),
        .Nquant     (Nquant),
        .K          (K),
        .mute       (mute),
        .busy       (busy)
`ifdef CANAL_CTRL_STATUS_EN
        ,
        .cfg_count  (cfg_count),
        .clamp_flag (clamp_flag)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_mute(input logic v, input int budget, input string tag, output int cycles);
        cycles = 0;
        while (mute !== v && cycles < budget) begin
            ticks(1);
            cycles++;
        end
        check(tag, 32'(mute), 32'(v));
    endtask

    function automatic logic [31:0] cfg_now();
        return 32'({sel_filter, sel_down, sel_requant, sel_interp, Nfreq, Nquant, K});
    endfunction

    function automatic logic [31:0] cfg(input logic [3:0] s, input logic [3:0] nf,
                                        input logic [4:0] nq, input logic [3:0] k);
        return 32'({s, nf, nq, k});
    endfunction

    initial begin
        // ---- reset values ----
        ticks(3);
        check("rst_cfg", cfg_now(), cfg(4'h0, 4'd1, 5'd18, 4'd1));
        check("rst_flags", 32'({data_en, frame_start, mute, busy}), 32'h0);
`ifdef CANAL_CTRL_STATUS_EN
        check("rst_status", 32'({cfg_count, clamp_flag}), 32'h0);
`endif
        reset = 1'b1;

        // ---- strobe: high on cycles 9, 19, 29; with Nfreq=1 every strobe starts a frame ----
        for (int i = 0; i < 30; i++) begin
            check("strobe", 32'(data_en), 32'(i % 10 == 9));
            check("fs_n1", 32'(frame_start), 32'(i % 10 == 9));
            ticks(1);
        end
        ticks(9);
        check("align1", 32'(data_en), 32'd1);

        // ---- glitch rejection (S = cycle 39) ----
        switches = 8'h01;
        ticks(2);
        check("gl_sync_busy0", 32'(busy), 32'd0);
        ticks(1);
        check("gl_debounce_busy1", 32'(busy), 32'd1);
        ticks(17);
        check("gl_strobe2", 32'(data_en), 32'd1);
        switches = 8'h00;
        ticks(10);
        check("gl_still_busy", 32'({busy, data_en}), 32'h3);
        ticks(1);
        check("gl_back_run", 32'({busy, mute}), 32'h0);
        check("gl_no_mute", 32'(mute_cycles), 32'd0);
        check("gl_cfg_kept", cfg_now(), cfg(4'h0, 4'd1, 5'd18, 4'd1));
        ticks(9);
        check("align2", 32'(data_en), 32'd1);

        // ---- normal apply 0x00 -> 0x3F (S2) ----
        switches = 8'h3F;
        ticks(40);
        check("na_4th_strobe", 32'({data_en, mute, busy}), 32'h5);
        ticks(1);
        check("na_mute_rise", 32'(mute), 32'd1);
        ticks(9);
        check("na_boundary", 32'(frame_start), 32'd1);
        check("na_cfg_pre", cfg_now(), cfg(4'h0, 4'd1, 5'd18, 4'd1));
        ticks(1);
        check("na_cfg_apply_cycle", cfg_now(), cfg(4'h0, 4'd1, 5'd18, 4'd1));
        ticks(1);
        check("na_cfg_new", cfg_now(), cfg(4'hF, 4'd3, 5'd18, 4'd3));
        ticks(8);
        check("na_fs_ph0", 32'({data_en, frame_start}), 32'h3);
        ticks(10);
        check("na_fs_ph1", 32'({data_en, frame_start}), 32'h2);
        ticks(20);
        check("na_fs_wrap", 32'({data_en, frame_start}), 32'h3);
        ticks(120);
        check("na_16th_strobe", 32'({data_en, mute}), 32'h3);
        ticks(1);
        check("na_mute_fall", 32'({mute, busy}), 32'h0);

        // ---- Nfreq field 0 clamp, then change presented during MUTE (S3) ----
        ticks(9);
        check("align3", 32'(data_en), 32'd1);
        switches = 8'h0F;
        ticks(41);
        check("cm_mute_rise", 32'(mute), 32'd1);
        ticks(11);
        check("cm_cfg_nf_clamp", cfg_now(), cfg(4'hF, 4'd1, 5'd18, 4'd1));
`ifdef CANAL_CTRL_STATUS_EN
        check("cm_status", 32'({cfg_count, clamp_flag}), 32'({8'd2, 1'b1}));
`endif
        ticks(8);
        switches = 8'h3F;
        ticks(150);
        check("cm_hold_in_mute", cfg_now(), cfg(4'hF, 4'd1, 5'd18, 4'd1));
        check("cm_mute_held", 32'(mute), 32'd1);
        ticks(1);
        check("cm_mute_fall", 32'({mute, busy}), 32'h0);
        ticks(1);
        check("cm_redebounce", 32'({mute, busy}), 32'h1);
        ticks(39);
        check("cm_mute_rise2", 32'(mute), 32'd1);
        ticks(10);
        check("cm_cfg_pre2", cfg_now(), cfg(4'hF, 4'd1, 5'd18, 4'd1));
        ticks(1);
        check("cm_cfg_new2", cfg_now(), cfg(4'hF, 4'd3, 5'd18, 4'd3));
        ticks(158);
        check("cm_mute_held2", 32'(mute), 32'd1);
        ticks(1);
        check("cm_mute_fall2", 32'({mute, busy}), 32'h0);

        // ---- Nquant clamping: 0 -> 1, 25 -> 18 ----
        nquant_req = 5'd0;
        wait_mute(1'b1, 80, "nq0_rise", took);
        wait_mute(1'b0, 400, "nq0_fall", took);
        check("nq0_cfg", cfg_now(), cfg(4'hF, 4'd3, 5'd1, 4'd3));
        nquant_req = 5'd25;
        wait_mute(1'b1, 80, "nq25_rise", took);
        wait_mute(1'b0, 400, "nq25_fall", took);
        check("nq25_cfg", cfg_now(), cfg(4'hF, 4'd3, 5'd18, 4'd3));
`ifdef CANAL_CTRL_STATUS_EN
        check("nq_status", 32'({cfg_count, clamp_flag}), 32'({8'd5, 1'b1}));
`endif

        // ---- reset asserted during WAIT_BOUNDARY ----
        switches = 8'h05;
        wait_mute(1'b1, 80, "wb_rise", took);
        reset = 1'b0;
        #1;
        check("rstwb_cfg", cfg_now(), cfg(4'h0, 4'd1, 5'd18, 4'd1));
        check("rstwb_flags", 32'({data_en, frame_start, mute, busy}), 32'h0);
`ifdef CANAL_CTRL_STATUS_EN
        check("rstwb_status", 32'({cfg_count, clamp_flag}), 32'h0);
`endif
        ticks(2);
        check("rstwb_held", 32'({data_en, mute, busy}), 32'h0);
        reset = 1'b1;
        ticks(2);
        check("rel_sync_busy0", 32'(busy), 32'd0);
        ticks(1);
        check("rel_debounce", 32'(busy), 32'd1);
        ticks(5);
        check("rel_no_strobe8", 32'(data_en), 32'd0);
        ticks(1);
        check("rel_strobe9", 32'(data_en), 32'd1);
        ticks(30);
        check("rel_mute_lo39", 32'(mute), 32'd0);
        ticks(1);
        check("rel_mute_hi40", 32'(mute), 32'd1);
        wait_mute(1'b0, 400, "rel_mute_fall", took);
        check("rel_cfg", cfg_now(), cfg(4'b1010, 4'd1, 5'd18, 4'd1));
`ifdef CANAL_CTRL_STATUS_EN
        check("rel_status", 32'({cfg_count, clamp_flag}), 32'({8'd1, 1'b1}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
